// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, load/store port and unified-memory signals around the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;

  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_ack_o;
  logic [DW-1:0] dm_rdata_o;

  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  logic          busy_o;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_ack_o, if_rdata_o,
    output dm_ack_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output busy_o
  );

  // CPU ports plus memory model side.
  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_ack_o, if_rdata_o,
    input  dm_ack_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  busy_o
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch (IF) and load/store (DM) requests.
// MEM_ARB_RR_EN selects round-robin on a tie; otherwise DM always beats IF.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  assign grant_valid = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
  // On a tie the port that did not own the previous transaction goes next.
  always_comb begin
    if (if_req && dm_req) begin
      grant_owner = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
    end else begin
      grant_owner = dm_req ? OWN_DM : OWN_IF;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  assign grant_owner = dm_req ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between CPU fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed DM-over-IF priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    dm_rdata_q, dm_rdata_d;
  logic             if_ack_q, if_ack_d;
  logic             dm_ack_q, dm_ack_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic             busy_q, busy_d;

  logic             grant_valid;
  logic             grant_owner;
  logic             pick_last_owner;

`ifdef MEM_ARB_RR_EN
  logic             last_owner_q, last_owner_d;
  assign pick_last_owner = last_owner_q;
`else
  assign pick_last_owner = OWN_IF;
`endif

  mem_arb_pick u_pick (
    .if_req      (bus.if_req_i),
    .dm_req      (bus.dm_req_i),
    .last_owner  (pick_last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Strobes and acks are computed for the next state so every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d  = grant_owner;
          cnt_d    = CNT_INIT;
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          if (grant_owner == OWN_DM) begin
            addr_d  = bus.dm_addr_i;
            we_d    = bus.dm_we_i;
            wdata_d = bus.dm_wdata_i;
          end else begin
            addr_d  = bus.if_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
          end
          mem_we_d = we_d;
`ifdef MEM_ARB_RR_EN
          last_owner_d = grant_owner;
`endif
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_DM) begin
            dm_ack_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = bus.mem_rdata_i;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata_i;
          end
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
          mem_we_d = we_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_DM;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset to IF so that DM wins the very first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_owner_q <= OWN_IF;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  assign bus.if_ack_o    = if_ack_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level model (honours MEM_ARB_RR_EN).
module tb_mem_port_arbiter;

  localparam int L  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.MEM_LAT(L), .AW(AW), .DW(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Read-only memory model: data is a pure function of the presented address.
  logic [DW-1:0] mem [64];
  assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    string       name;
    bit          isDm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expIf;
    logic [31:0] expDm;
  } vec_t;

  vec_t vecs [6];

  // Transaction-level reference model state for the random phase.
  bit          mActive;
  int          mK;
  bit          mOwnerDm;
  bit          mLastDm;
  bit          tWe;
  logic [31:0] tAddr;
  logic [31:0] tWdata;
  logic [31:0] mIfR;
  logic [31:0] mDmR;

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual=%b expected=%b", name, act, exp);
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  task automatic checkOutput(input string tag, input bit ifAck, input bit dmAck,
                             input bit en, input bit busy);
    checkBit({tag, " if_ack"}, bus.if_ack_o, ifAck);
    checkBit({tag, " dm_ack"}, bus.dm_ack_o, dmAck);
    checkBit({tag, " mem_en"}, bus.mem_en_o, en);
    checkBit({tag, " busy"}, bus.busy_o, busy);
  endtask

  task automatic applyStimulus(input bit ifReq, input logic [31:0] ifAddr, input bit dmReq,
                               input bit dmWe, input logic [31:0] dmAddr,
                               input logic [31:0] dmWdata);
    bus.if_req_i   = ifReq;
    bus.if_addr_i  = ifAddr;
    bus.dm_req_i   = dmReq;
    bus.dm_we_i    = dmWe;
    bus.dm_addr_i  = dmAddr;
    bus.dm_wdata_i = dmWdata;
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // One isolated transaction, started from an idle cycle.
  task automatic runTransaction(input vec_t v);
    applyStimulus(!v.isDm, v.addr, v.isDm, v.we, v.addr, v.wdata);
    for (int c = 1; c <= L + 1; c++) begin
      tick();
      if (c <= L) begin
        checkOutput($sformatf("%s c%0d", v.name, c), 1'b0, 1'b0, 1'b1, 1'b1);
        checkBit($sformatf("%s c%0d mem_we", v.name, c), bus.mem_we_o, v.we);
        checkWord($sformatf("%s c%0d mem_addr", v.name, c), bus.mem_addr_o, v.addr);
        if (v.we) checkWord($sformatf("%s c%0d mem_wdata", v.name, c), bus.mem_wdata_o, v.wdata);
      end else begin
        checkOutput($sformatf("%s ack", v.name), !v.isDm, v.isDm, 1'b0, 1'b1);
        checkWord($sformatf("%s if_rdata", v.name), bus.if_rdata_o, v.expIf);
        checkWord($sformatf("%s dm_rdata", v.name), bus.dm_rdata_o, v.expDm);
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput($sformatf("%s idle", v.name), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          ifPend, dmPend, dmW;
    logic [31:0] ifA, dmA, dmD;
    bit          expEn, ackIf, ackDm;

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'h0000_0013;
    mem[2]  = 32'h2002_000A;
    mem[4]  = 32'h8C01_0004;
    mem[8]  = 32'h55AA_55AA;
    mem[16] = 32'h1111_2222;

    vecs[0] = '{"if_rd_10", 1'b0, 1'b0, 32'h10, 32'h0,         32'h8C01_0004, 32'h0};
    vecs[1] = '{"dm_st_20", 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h8C01_0004, 32'h0};
    vecs[2] = '{"dm_ld_40", 1'b1, 1'b0, 32'h40, 32'h0,         32'h8C01_0004, 32'h1111_2222};
    vecs[3] = '{"dm_st_24", 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h8C01_0004, 32'h1111_2222};
    vecs[4] = '{"if_rd_08", 1'b0, 1'b0, 32'h08, 32'h0,         32'h2002_000A, 32'h1111_2222};
    vecs[5] = '{"dm_ld_20", 1'b1, 1'b0, 32'h20, 32'h0,         32'h2002_000A, 32'h55AA_55AA};

    // Reset with random inputs present.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom);
      #3;
      checkOutput($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      checkBit("rst mem_we", bus.mem_we_o, 1'b0);
      checkWord("rst mem_addr", bus.mem_addr_o, 32'h0);
      checkWord("rst mem_wdata", bus.mem_wdata_o, 32'h0);
      checkWord("rst if_rdata", bus.if_rdata_o, 32'h0);
      checkWord("rst dm_rdata", bus.dm_rdata_o, 32'h0);
      #7;
    end
    @(negedge clk_i);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("post_rst c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Simultaneous IF(0x0) and DM load(0x40): DM first, IF re-arbitrated afterwards.
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      expEn = (c == 1 || c == 2 || c == 5 || c == 6);
      checkOutput($sformatf("both c%0d", c), c == 7, c == 3, expEn, c != 4);
      if (c <= 2) checkWord($sformatf("both c%0d addr", c), bus.mem_addr_o, 32'h40);
      if (c == 5 || c == 6) checkWord($sformatf("both c%0d addr", c), bus.mem_addr_o, 32'h0);
      if (c == 3) begin
        checkWord("both dm_rdata", bus.dm_rdata_o, 32'h1111_2222);
        bus.dm_req_i = 1'b0;
      end
      if (c == 7) checkWord("both if_rdata", bus.if_rdata_o, 32'h0000_0013);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("both idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Both requests held continuously: one ack every L+2 cycles.
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      tick();
      ackDm = 1'b0;
      ackIf = 1'b0;
      if (c % 4 == 3) begin
`ifdef MEM_ARB_RR_EN
        ackDm = ((c / 4) % 2 == 0);
`else
        ackDm = 1'b1;
`endif
        ackIf = !ackDm;
      end
      checkOutput($sformatf("hold c%0d", c), ackIf, ackDm, (c % 4 == 1) || (c % 4 == 2), c % 4 != 0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("hold idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the second ACCESS cycle of a DM load.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    tick();
    checkOutput("rmid access", 1'b0, 1'b0, 1'b1, 1'b1);
    rst_i = 1'b0;
    #1;
    checkOutput("rmid async", 1'b0, 1'b0, 1'b0, 1'b0);
    checkWord("rmid dm_rdata", bus.dm_rdata_o, 32'h0);
    checkWord("rmid mem_addr", bus.mem_addr_o, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("rmid held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    tick();
    checkOutput("rmid released", 1'b0, 1'b0, 1'b0, 1'b0);
    runTransaction('{"rmid_if_08", 1'b0, 1'b0, 32'h08, 32'h0, 32'h2002_000A, 32'h0});

    // Table-driven single transactions.
    for (int i = 0; i < 6; i++) runTransaction(vecs[i]);

    // Randomized traffic against the transaction-level model.
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    mActive = 1'b0;
    mK      = 0;
    mOwnerDm = 1'b1;
    mLastDm = 1'b0;
    mIfR    = 32'h0;
    mDmR    = 32'h0;
    tWe     = 1'b0;
    tAddr   = 32'h0;
    tWdata  = 32'h0;
    ifPend  = 1'b0;
    dmPend  = 1'b0;
    dmW     = 1'b0;
    ifA     = 32'h0;
    dmA     = 32'h0;
    dmD     = 32'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      expEn = mActive && (mK <= L);
      ackIf = mActive && (mK == L + 1) && !mOwnerDm;
      ackDm = mActive && (mK == L + 1) && mOwnerDm;
      checkOutput($sformatf("rnd%0d", cyc), ackIf, ackDm, expEn, mActive);
      checkBit($sformatf("rnd%0d mem_we", cyc), bus.mem_we_o, expEn && tWe);
      if (expEn) checkWord($sformatf("rnd%0d mem_addr", cyc), bus.mem_addr_o, tAddr);
      if (expEn && tWe) checkWord($sformatf("rnd%0d mem_wdata", cyc), bus.mem_wdata_o, tWdata);
      checkWord($sformatf("rnd%0d if_rdata", cyc), bus.if_rdata_o, mIfR);
      checkWord($sformatf("rnd%0d dm_rdata", cyc), bus.dm_rdata_o, mDmR);

      if (ifPend && ackIf) ifPend = 1'b0;
      if (dmPend && ackDm) dmPend = 1'b0;
      if (!ifPend && $urandom_range(2, 0) == 0) begin
        ifPend = 1'b1;
        ifA    = $urandom;
      end
      if (!dmPend && $urandom_range(2, 0) == 0) begin
        dmPend = 1'b1;
        dmW    = 1'($urandom);
        dmA    = $urandom;
        dmD    = $urandom;
      end
      applyStimulus(ifPend, ifPend ? ifA : $urandom, dmPend, dmW, dmPend ? dmA : $urandom,
                    dmPend ? dmD : $urandom);
      // The owner's address/data may wander while its access is in flight.
      if (mActive && mK <= L) begin
        if (mOwnerDm) begin
          bus.dm_addr_i  = $urandom;
          bus.dm_wdata_i = $urandom;
        end else begin
          bus.if_addr_i = $urandom;
        end
      end

      if (mActive) begin
        if (mK == L && !tWe) begin
          if (mOwnerDm) mDmR = mem[tAddr[7:2]];
          else          mIfR = mem[tAddr[7:2]];
        end
        if (mK == L + 1) mActive = 1'b0;
        else             mK++;
      end else if (ifPend || dmPend) begin
`ifdef MEM_ARB_RR_EN
        mOwnerDm = (ifPend && dmPend) ? !mLastDm : dmPend;
`else
        mOwnerDm = dmPend;
`endif
        mLastDm = mOwnerDm;
        tAddr   = mOwnerDm ? dmA : ifA;
        tWe     = mOwnerDm ? dmW : 1'b0;
        tWdata  = dmD;
        mActive = 1'b1;
        mK      = 1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
